// File: rtl/eflags_writer.sv
// Producer of the architectural EFLAGS register: decodes flag-setting micro-ops,
// captures operands, computes CF/PF/ZF/SF/OF and commits them in order.
module eflags_writer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [5:0]  opcode,
   input  logic [63:0] src_s,
   input  logic [63:0] src_t,
   input  logic        flush,
   input  logic        wr_en,
   input  logic [63:0] wr_data,
   output logic [63:0] eflags,
   output logic        busy,
   output logic        committed
);

   localparam int unsigned REG_W    = 64;
   localparam int unsigned OPCODE_W = 6;

   localparam int unsigned EFLAGS_CF = 0;
   localparam int unsigned EFLAGS_PF = 2;
   localparam int unsigned EFLAGS_ZF = 6;
   localparam int unsigned EFLAGS_SF = 7;
   localparam int unsigned EFLAGS_OF = 11;

   localparam logic [REG_W-1:0] EFLAGS_RESET = REG_W'(64'h2);

   localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_ADC   = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_ADCI  = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_SBB   = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_SBBI  = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_CMP   = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_CMPI  = OPCODE_W'(9);
   localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(11);
   localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(12);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
   localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(14);
   localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(15);
   localparam logic [OPCODE_W-1:0] OP_TEST  = OPCODE_W'(16);
   localparam logic [OPCODE_W-1:0] OP_TESTI = OPCODE_W'(17);

   localparam logic [1:0] CLS_ADD   = 2'd0;
   localparam logic [1:0] CLS_SUB   = 2'd1;
   localparam logic [1:0] CLS_LOGIC = 2'd2;

   localparam logic [1:0] LOP_AND = 2'd0;
   localparam logic [1:0] LOP_OR  = 2'd1;
   localparam logic [1:0] LOP_XOR = 2'd2;

   // decode outputs
   logic       writes_flags_c;
   logic [1:0] cls_c;
   logic [1:0] lop_c;
   logic       use_cf_c;

   // captured op (stage 1) and in-flight tracking
   logic             valid1;
   logic             valid2;
   logic [1:0]       cls1;
   logic [1:0]       lop1;
   logic             use_cf1;
   logic [REG_W-1:0] s1;
   logic [REG_W-1:0] t1;

   logic             v1_next_c;
   logic             v2_next_c;
   logic             commit_c;
   logic             cin_c;
   logic [REG_W:0]   sum_c;
   logic [REG_W:0]   diff_c;
   logic [REG_W-1:0] res_c;
   logic             cf_c;
   logic             of_c;
   logic [REG_W-1:0] flags_next_c;

   // opcode decode into class, logic subtype and carry-use
   always_comb begin
      writes_flags_c = 1'b0;
      cls_c          = CLS_ADD;
      lop_c          = LOP_AND;
      use_cf_c       = 1'b0;
      unique case (opcode)
         OP_ADD, OP_ADDI: begin writes_flags_c = 1'b1; cls_c = CLS_ADD; end
         OP_ADC, OP_ADCI: begin writes_flags_c = 1'b1; cls_c = CLS_ADD; use_cf_c = 1'b1; end
         OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: begin writes_flags_c = 1'b1; cls_c = CLS_SUB; end
         OP_SBB, OP_SBBI: begin writes_flags_c = 1'b1; cls_c = CLS_SUB; use_cf_c = 1'b1; end
         OP_AND, OP_ANDI, OP_TEST, OP_TESTI: begin writes_flags_c = 1'b1; cls_c = CLS_LOGIC; lop_c = LOP_AND; end
         OP_OR, OP_ORI: begin writes_flags_c = 1'b1; cls_c = CLS_LOGIC; lop_c = LOP_OR; end
         OP_XOR, OP_XORI: begin writes_flags_c = 1'b1; cls_c = CLS_LOGIC; lop_c = LOP_XOR; end
         default: ;
      endcase
   end

   // flag computation; CF of the previous op is already committed, so read it directly
   always_comb begin
      cin_c  = use_cf1 & eflags[EFLAGS_CF];
      sum_c  = {1'b0, s1} + {1'b0, t1} + (REG_W+1)'(cin_c);
      diff_c = {1'b0, s1} - {1'b0, t1} - (REG_W+1)'(cin_c);
      res_c  = '0;
      cf_c   = 1'b0;
      of_c   = 1'b0;
      case (cls1)
         CLS_ADD: begin
            res_c = sum_c[REG_W-1:0];
            cf_c  = sum_c[REG_W];
            of_c  = (s1[REG_W-1] == t1[REG_W-1]) & (res_c[REG_W-1] != s1[REG_W-1]);
         end
         CLS_SUB: begin
            res_c = diff_c[REG_W-1:0];
            cf_c  = diff_c[REG_W];
            of_c  = (s1[REG_W-1] != t1[REG_W-1]) & (res_c[REG_W-1] != s1[REG_W-1]);
         end
         default: begin
            case (lop1)
               LOP_OR:  res_c = s1 | t1;
               LOP_XOR: res_c = s1 ^ t1;
               default: res_c = s1 & t1;
            endcase
         end
      endcase
      flags_next_c            = eflags;
      flags_next_c[EFLAGS_CF] = cf_c;
      flags_next_c[EFLAGS_PF] = ~^res_c[7:0];
      flags_next_c[EFLAGS_ZF] = (res_c == '0);
      flags_next_c[EFLAGS_SF] = res_c[REG_W-1];
      flags_next_c[EFLAGS_OF] = of_c;
   end

   // pipeline control: flush kills both stages, direct write beats a commit
   always_comb begin
      v1_next_c = in_valid & writes_flags_c & ~flush;
      v2_next_c = valid1 & ~flush;
      commit_c  = valid1 & ~flush & ~wr_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid1    <= 1'b0;
         valid2    <= 1'b0;
         cls1      <= CLS_ADD;
         lop1      <= LOP_AND;
         use_cf1   <= 1'b0;
         s1        <= '0;
         t1        <= '0;
         eflags    <= EFLAGS_RESET;
         busy      <= 1'b0;
         committed <= 1'b0;
      end else begin
         valid1    <= v1_next_c;
         valid2    <= v2_next_c;
         busy      <= v1_next_c | v2_next_c;
         committed <= commit_c;
         if (v1_next_c) begin
            cls1    <= cls_c;
            lop1    <= lop_c;
            use_cf1 <= use_cf_c;
            s1      <= src_s;
            t1      <= src_t;
         end
         if (wr_en)
            eflags <= wr_data;
         else if (commit_c)
            eflags <= flags_next_c;
      end
   end

endmodule

// File: tb/tb_eflags_writer.sv
// Directed bench for eflags_writer with hand-computed EFLAGS values.
module tb_eflags_writer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [63:0] src_s;
   logic [63:0] src_t;
   logic        flush;
   logic        wr_en;
   logic [63:0] wr_data;
   logic [63:0] eflags;
   logic        busy;
   logic        committed;

   int tests_run;
   int tests_failed;

   localparam logic [5:0] OP_ADD   = 6'd0;
   localparam logic [5:0] OP_ADCI  = 6'd3;
   localparam logic [5:0] OP_SUB   = 6'd4;
   localparam logic [5:0] OP_SBB   = 6'd6;
   localparam logic [5:0] OP_CMP   = 6'd8;
   localparam logic [5:0] OP_XOR   = 6'd14;
   localparam logic [5:0] OP_TESTI = 6'd17;
   localparam logic [5:0] OP_MUL   = 6'd18;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   eflags_writer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
      .src_s(src_s), .src_t(src_t), .flush(flush), .wr_en(wr_en),
      .wr_data(wr_data), .eflags(eflags), .busy(busy), .committed(committed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [5:0] op, input logic [63:0] s, input logic [63:0] t);
      in_valid = 1'b1;
      opcode   = op;
      src_s    = s;
      src_t    = t;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset_values();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tests_run++;
      if (eflags !== 64'h2 || busy !== 1'b0 || committed !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_values: eflags=%h busy=%b committed=%b required eflags=2 busy=0 committed=0",
                  eflags, busy, committed);
      end
   endtask

   task automatic test_add_overflow();
      logic b1, c1, b2, c2;
      present(OP_ADD, ONES, 64'h1);
      b1 = busy; c1 = committed;
      tick();
      b2 = busy; c2 = committed;
      tests_run++;
      if (eflags !== 64'h47) begin
         tests_failed++;
         $display("FAIL add_overflow_flags: eflags=%h required 47", eflags);
      end
      tests_run++;
      if ({b1, c1, b2, c2} !== 4'b1011) begin
         tests_failed++;
         $display("FAIL add_overflow_timing: busy/committed c1=%b%b c2=%b%b required 10 11", b1, c1, b2, c2);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0 || committed !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_overflow_idle: busy=%b committed=%b required 0 0", busy, committed);
      end
   endtask

   task automatic test_sub_overflow();
      present(OP_SUB, 64'h8000_0000_0000_0000, 64'h1);
      tick();
      tests_run++;
      if (eflags !== 64'h806) begin
         tests_failed++;
         $display("FAIL sub_overflow: eflags=%h required 806", eflags);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; opcode = OP_ADD; src_s = ONES; src_t = 64'h1;
      tick();
      opcode = OP_ADCI; src_s = 64'h0; src_t = 64'h0;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (eflags !== 64'h47 || committed !== 1'b1) begin
         tests_failed++;
         $display("FAIL chain_first: eflags=%h committed=%b required 47 1", eflags, committed);
      end
      tick();
      tests_run++;
      if (eflags !== 64'h2 || committed !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL chain_adc: eflags=%h committed=%b busy=%b required 2 1 1", eflags, committed, busy);
      end
      tick();
   endtask

   task automatic test_sbb_borrow();
      // set CF first, then 5 - 5 - 1 wraps to all ones with borrow
      present(OP_ADD, ONES, 64'h1);
      present(OP_SBB, 64'h5, 64'h5);
      tick();
      tests_run++;
      if (eflags !== 64'h87) begin
         tests_failed++;
         $display("FAIL sbb_borrow: eflags=%h required 87", eflags);
      end
      present(OP_CMP, 64'h7, 64'h7);
      tick();
      tests_run++;
      if (eflags !== 64'h46) begin
         tests_failed++;
         $display("FAIL cmp_equal: eflags=%h required 46", eflags);
      end
   endtask

   task automatic test_logic_and_preserve();
      present(OP_XOR, 64'h8000_0000_0000_0000, 64'h1);
      tick();
      tests_run++;
      if (eflags !== 64'h82) begin
         tests_failed++;
         $display("FAIL xor_sign: eflags=%h required 82", eflags);
      end
      wr_en = 1'b1; wr_data = 64'h0202;
      tick();
      wr_en = 1'b0;
      tests_run++;
      if (eflags !== 64'h202) begin
         tests_failed++;
         $display("FAIL direct_write: eflags=%h required 202", eflags);
      end
      present(OP_TESTI, 64'hF0, 64'h0F);
      tick();
      tests_run++;
      if (eflags !== 64'h246) begin
         tests_failed++;
         $display("FAIL testi_preserve: eflags=%h required 246", eflags);
      end
   endtask

   task automatic test_ignored_op();
      logic b;
      present(OP_MUL, ONES, ONES);
      b = busy;
      tick();
      tests_run++;
      if (b !== 1'b0 || eflags !== 64'h246 || committed !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_mul: busy=%b eflags=%h committed=%b required 0 246 0", b, eflags, committed);
      end
   endtask

   task automatic test_flush();
      present(OP_ADD, 64'h1, 64'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tests_run++;
      if (eflags !== 64'h246 || committed !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush: eflags=%h committed=%b busy=%b required 246 0 0", eflags, committed, busy);
      end
   endtask

   task automatic test_wr_priority();
      present(OP_ADD, ONES, 64'h1);
      wr_en = 1'b1; wr_data = 64'h2;
      tick();
      wr_en = 1'b0;
      tests_run++;
      if (eflags !== 64'h2 || committed !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_priority: eflags=%h committed=%b required 2 0", eflags, committed);
      end
      tick();
   endtask

   task automatic test_async_reset();
      present(OP_ADD, ONES, 64'h1);
      tick();
      present(OP_ADD, ONES, 64'h1);
      tick();
      // second op is in flight with committed high; reset must clear without an edge
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (eflags !== 64'h2 || busy !== 1'b0 || committed !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: eflags=%h busy=%b committed=%b required 2 0 0", eflags, busy, committed);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b0; in_valid = 1'b0; opcode = '0; src_s = '0; src_t = '0;
      flush = 1'b0; wr_en = 1'b0; wr_data = '0;
      #2;
      test_reset_values();
      test_add_overflow();
      test_sub_overflow();
      test_back_to_back();
      test_sbb_borrow();
      test_logic_and_preserve();
      test_ignored_op();
      test_flush();
      test_wr_priority();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
